// File: rtl/ballot_pkg.sv
// Shared types and default constants for the ballot tally engine.
package ballot_pkg;

    // FSM states with a fixed 2-bit encoding that is also exported on the state port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_TALLY  = 2'd2,
        ST_RESULT = 2'd3
    } ballot_state_t;

    localparam int DEF_NUM_CAND = 8;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_TOT_W    = 12;
    localparam int DEF_VID_W    = 4;

endpackage

// File: rtl/ballot_tally_engine_if.sv
// Vote submission handshake between a ballot source (master) and the tally engine (slave).
interface ballot_tally_engine_if
    import ballot_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int VID_W    = DEF_VID_W
) ();

    logic                        vote_valid;
    logic                        vote_ready;
    logic [$clog2(NUM_CAND)-1:0] vote_cand;
    logic [VID_W-1:0]            vote_vid;
    logic                        vote_ack;
    logic                        vote_nack;

    modport master (
        output vote_valid, vote_cand, vote_vid,
        input  vote_ready, vote_ack, vote_nack
    );

    modport slave (
        input  vote_valid, vote_cand, vote_vid,
        output vote_ready, vote_ack, vote_nack
    );

endinterface

// File: rtl/ballot_max_scan.sv
// Sequential max/tie finder: walks candidate indices 0..NUM_CAND-1, one per cycle,
// while run is held. The lowest index wins ties; tie_seen flags a later equal count.
module ballot_max_scan
    import ballot_pkg::*;
#(
    parameter int  NUM_CAND = DEF_NUM_CAND,
    parameter int  CNT_W    = DEF_CNT_W,
    localparam int CAND_W   = $clog2(NUM_CAND)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [CNT_W-1:0]  scan_cnt,
    output logic [CAND_W-1:0] scan_idx,
    output logic              scan_done,
    output logic [CAND_W-1:0] max_idx,
    output logic [CNT_W-1:0]  max_val,
    output logic              tie_seen
);

    localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

    assign scan_done = run && (scan_idx == LAST_IDX);

    // Scan index: parked at 0 when idle, advances once per cycle while running
    // NOTE: flops are written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            scan_idx <= '0;
        end else if (!scan_done) begin
            scan_idx <= scan_idx + 1'b1;
        end
    end

    // Running maximum: seeded at index 0, replaced only on strictly greater
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_idx  <= '0;
            max_val  <= '0;
            tie_seen <= 1'b0;
        end else if (run) begin
            if (scan_idx == '0) begin
                max_idx  <= '0;
                max_val  <= scan_cnt;
                tie_seen <= 1'b0;
            end else if (scan_cnt > max_val) begin
                max_idx  <= scan_idx;
                max_val  <= scan_cnt;
                tie_seen <= 1'b0;
            end else if (scan_cnt == max_val) begin
                tie_seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ballot_tally_engine.sv
// Ballot tally engine: accepts votes while the poll is open, keeps saturating
// per-candidate and total counts, then scans for the winner after close.
// Optional feature: define VOTER_LOCKOUT_EN to reject repeat votes from the same
// voter ID until cmd_clear or reset. Without it, vote_vid is ignored.
module ballot_tally_engine
    import ballot_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TOT_W    = DEF_TOT_W,
    parameter int VID_W    = DEF_VID_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_open,
    input  logic                        cmd_close,
    input  logic                        cmd_clear,
    ballot_tally_engine_if.slave        vote,
    output logic [1:0]                  state,
    output logic [$clog2(NUM_CAND)-1:0] winner_idx,
    output logic                        winner_valid,
    output logic                        tie,
    output logic [TOT_W-1:0]            total,
    input  logic [$clog2(NUM_CAND)-1:0] rd_sel,
    output logic [CNT_W-1:0]            rd_count
);

    localparam int               CAND_W  = $clog2(NUM_CAND);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    ballot_state_t     cur_state;
    ballot_state_t     nxt_state;
    logic [CNT_W-1:0]  counts [NUM_CAND];

    logic              accept;
    logic              vote_ok;
    logic              cand_hit;
    logic [CNT_W-1:0]  sel_cnt;
    logic              used_hit;

    logic              scan_run;
    logic              scan_done;
    logic [CAND_W-1:0] scan_idx;
    logic [CNT_W-1:0]  scan_cnt;
    logic [CAND_W-1:0] scan_max_idx;
    logic [CNT_W-1:0]  scan_max_val;
    logic              scan_tie;

    assign state = cur_state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next state: clear beats everything; strobes invalid in the current state are ignored
    // NOTE: nxt_state gets a default before any branch so no path can infer a latch.
    always_comb begin
        nxt_state = cur_state;
        if (cmd_clear) begin
            nxt_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE:   if (cmd_open)  nxt_state = ST_OPEN;
                ST_OPEN:   if (cmd_close) nxt_state = ST_TALLY;
                ST_TALLY:  if (scan_done) nxt_state = ST_RESULT;
                ST_RESULT: nxt_state = ST_RESULT;
                default:   nxt_state = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs: ready only while open, results only visible in RESULT
    always_comb begin
        vote.vote_ready = 1'b0;
        scan_run        = 1'b0;
        winner_valid    = 1'b0;
        winner_idx      = '0;
        tie             = 1'b0;
        case (cur_state)
            ST_OPEN:   vote.vote_ready = 1'b1;
            ST_TALLY:  scan_run = 1'b1;
            ST_RESULT: begin
                winner_valid = (scan_max_val != '0);
                winner_idx   = winner_valid ? scan_max_idx : '0;
                tie          = winner_valid && scan_tie;
            end
            default: ;
        endcase
    end

    // Count lookups for the vote path, the read port and the scanner
    always_comb begin
        cand_hit = 1'b0;
        sel_cnt  = '0;
        rd_count = '0;
        scan_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote.vote_cand == CAND_W'(i)) begin
                cand_hit = 1'b1;
                sel_cnt  = counts[i];
            end
            if (rd_sel == CAND_W'(i)) begin
                rd_count = counts[i];
            end
            if (scan_idx == CAND_W'(i)) begin
                scan_cnt = counts[i];
            end
        end
    end

    assign accept  = vote.vote_valid && vote.vote_ready;
    assign vote_ok = cand_hit && (sel_cnt != CNT_MAX) && (total != TOT_MAX) && !used_hit;

`ifdef VOTER_LOCKOUT_EN
    logic [2**VID_W-1:0] used_map;

    assign used_hit = used_map[vote.vote_vid];

    // Voter lockout map: only acknowledged votes mark the voter as used
    always_ff @(posedge clk) begin
        if (!rst_n || cmd_clear) begin
            used_map <= '0;
        end else if (accept && vote_ok) begin
            used_map[vote.vote_vid] <= 1'b1;
        end
    end
`else
    logic unused_vid;

    assign unused_vid = ^vote.vote_vid;
    assign used_hit   = 1'b0;
`endif

    // Per-candidate and total counters; the nack conditions already block saturation
    // NOTE: the count array is reset element by element because clear must zero it; it maps to flops, not RAM.
    always_ff @(posedge clk) begin
        if (!rst_n || cmd_clear) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                counts[i] <= '0;
            end
            total <= '0;
        end else if (accept && vote_ok) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (vote.vote_cand == CAND_W'(i)) begin
                    counts[i] <= counts[i] + 1'b1;
                end
            end
            total <= total + 1'b1;
        end
    end

    // One-cycle result pulse for each accepted vote, aligned with its count update
    always_ff @(posedge clk) begin
        if (!rst_n || cmd_clear) begin
            vote.vote_ack  <= 1'b0;
            vote.vote_nack <= 1'b0;
        end else begin
            vote.vote_ack  <= accept && vote_ok;
            vote.vote_nack <= accept && !vote_ok;
        end
    end

    ballot_max_scan #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_max_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (scan_run),
        .scan_cnt  (scan_cnt),
        .scan_idx  (scan_idx),
        .scan_done (scan_done),
        .max_idx   (scan_max_idx),
        .max_val   (scan_max_val),
        .tie_seen  (scan_tie)
    );

endmodule

// File: tb/tb_ballot_tally_engine.sv
// Self-checking bench for ballot_tally_engine: directed scenarios plus randomized polls
// checked against an array-based reference model. A second, narrow instance exercises
// counter/total saturation and out-of-range candidates.
module tb_ballot_tally_engine;
    import ballot_pkg::*;

    localparam int NC  = 8;
    localparam int CW  = 8;
    localparam int TW  = 12;
    localparam int VW  = 4;
    localparam int SNC = 3;
    localparam int SCW = 2;
    localparam int STW = 3;

`ifdef VOTER_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    // Main instance
    logic          cmd_open  = 1'b0;
    logic          cmd_close = 1'b0;
    logic          cmd_clear = 1'b0;
    logic [1:0]    state;
    logic [2:0]    winner_idx;
    logic          winner_valid;
    logic          tie;
    logic [TW-1:0] total;
    logic [2:0]    rd_sel = '0;
    logic [CW-1:0] rd_count;

    ballot_tally_engine_if #(.NUM_CAND(NC), .VID_W(VW)) vif ();

    ballot_tally_engine #(.NUM_CAND(NC), .CNT_W(CW), .TOT_W(TW), .VID_W(VW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_open     (cmd_open),
        .cmd_close    (cmd_close),
        .cmd_clear    (cmd_clear),
        .vote         (vif),
        .state        (state),
        .winner_idx   (winner_idx),
        .winner_valid (winner_valid),
        .tie          (tie),
        .total        (total),
        .rd_sel       (rd_sel),
        .rd_count     (rd_count)
    );

    // Narrow instance for saturation corners
    logic           s_open  = 1'b0;
    logic           s_close = 1'b0;
    logic           s_clear = 1'b0;
    logic [1:0]     s_state;
    logic [1:0]     s_winner_idx;
    logic           s_winner_valid;
    logic           s_tie;
    logic [STW-1:0] s_total;
    logic [1:0]     s_rd_sel = '0;
    logic [SCW-1:0] s_rd_count;

    ballot_tally_engine_if #(.NUM_CAND(SNC), .VID_W(VW)) svif ();

    ballot_tally_engine #(.NUM_CAND(SNC), .CNT_W(SCW), .TOT_W(STW), .VID_W(VW)) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_open     (s_open),
        .cmd_close    (s_close),
        .cmd_clear    (s_clear),
        .vote         (svif),
        .state        (s_state),
        .winner_idx   (s_winner_idx),
        .winner_valid (s_winner_valid),
        .tie          (s_tie),
        .total        (s_total),
        .rd_sel       (s_rd_sel),
        .rd_count     (s_rd_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain counts per candidate, a total and a set of used voter IDs
    int m_cnt [NC];
    int m_total;
    bit m_used [2**VW];

    task automatic model_clear();
        foreach (m_cnt[i])  m_cnt[i]  = 0;
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_total = 0;
    endtask

    function automatic bit model_vote(int cand, int vid);
        bit ok;
        ok = (cand < NC) && (m_cnt[cand] < 2**CW - 1) && (m_total < 2**TW - 1);
        if (LOCKOUT && m_used[vid]) ok = 1'b0;
        if (ok) begin
            m_cnt[cand]++;
            m_total++;
            if (LOCKOUT) m_used[vid] = 1'b1;
        end
        return ok;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(int cand, int vid, string tag);
        bit exp_ack;
        vif.vote_valid = 1'b1;
        vif.vote_cand  = 3'(cand);
        vif.vote_vid   = 4'(vid);
        check({tag, "_ready"}, 32'(vif.vote_ready), 1);
        exp_ack = model_vote(cand, vid);
        step();
        vif.vote_valid = 1'b0;
        check({tag, "_ack"},   32'(vif.vote_ack),  32'(exp_ack));
        check({tag, "_nack"},  32'(vif.vote_nack), 32'(!exp_ack));
        check({tag, "_total"}, 32'(total),         m_total);
    endtask

    task automatic check_counts(string tag);
        for (int i = 0; i < NC; i++) begin
            rd_sel = 3'(i);
            #1;
            check({tag, "_rd_count"}, 32'(rd_count), m_cnt[i]);
        end
    endtask

    task automatic do_open(string tag);
        cmd_open = 1'b1;
        step();
        cmd_open = 1'b0;
        check({tag, "_open_state"}, 32'(state), 1);
    endtask

    // Called right after the edge that entered TALLY
    task automatic run_scan(string tag);
        int mx;
        int widx;
        int ties;
        check({tag, "_tally_state"}, 32'(state), 2);
        repeat (NC - 1) step();
        check({tag, "_tally_last"}, 32'(state), 2);
        step();
        check({tag, "_result_state"}, 32'(state), 3);
        mx = 0; widx = 0; ties = 0;
        for (int i = 0; i < NC; i++) begin
            if (m_cnt[i] > mx) begin
                mx   = m_cnt[i];
                widx = i;
            end
        end
        for (int i = 0; i < NC; i++) if (m_cnt[i] == mx) ties++;
        check({tag, "_winner_idx"},   32'(winner_idx),   widx);
        check({tag, "_winner_valid"}, 32'(winner_valid), 32'(mx > 0));
        check({tag, "_tie"},          32'(tie),          32'(mx > 0 && ties > 1));
        check({tag, "_total"},        32'(total),        m_total);
    endtask

    task automatic do_close(string tag);
        cmd_close = 1'b1;
        step();
        cmd_close = 1'b0;
        run_scan(tag);
    endtask

    task automatic do_clear(string tag);
        cmd_clear = 1'b1;
        step();
        cmd_clear = 1'b0;
        model_clear();
        check({tag, "_clr_state"},  32'(state),        0);
        check({tag, "_clr_total"},  32'(total),        0);
        check({tag, "_clr_wvalid"}, 32'(winner_valid), 0);
        check({tag, "_clr_widx"},   32'(winner_idx),   0);
        check({tag, "_clr_tie"},    32'(tie),          0);
    endtask

    task automatic s_vote(int cand, int vid, bit exp_ack, string tag);
        svif.vote_valid = 1'b1;
        svif.vote_cand  = 2'(cand);
        svif.vote_vid   = 4'(vid);
        step();
        svif.vote_valid = 1'b0;
        check({tag, "_ack"},  32'(svif.vote_ack),  32'(exp_ack));
        check({tag, "_nack"}, 32'(svif.vote_nack), 32'(!exp_ack));
    endtask

    initial begin
        vif.vote_valid  = 1'b0;
        vif.vote_cand   = '0;
        vif.vote_vid    = '0;
        svif.vote_valid = 1'b0;
        svif.vote_cand  = '0;
        svif.vote_vid   = '0;
        model_clear();

        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        check("rst_state",   32'(state),          0);
        check("rst_total",   32'(total),          0);
        check("rst_ack",     32'(vif.vote_ack),   0);
        check("rst_nack",    32'(vif.vote_nack),  0);
        check("rst_ready",   32'(vif.vote_ready), 0);
        check("rst_widx",    32'(winner_idx),     0);
        check("rst_wvalid",  32'(winner_valid),   0);
        check("rst_tie",     32'(tie),            0);
        check("rst_s_state", 32'(s_state),        0);
        check("rst_s_total", 32'(s_total),        0);
        rst_n = 1'b1;
        step();

        // Clear winner: 2,2,5
        do_open("a");
        vote(2, 1, "a1");
        vote(2, 2, "a2");
        vote(5, 3, "a3");
        check_counts("a");
        do_close("a");
        check("a_winner_is_2", 32'(winner_idx), 2);
        do_clear("a");

        // Two-way tie: lowest index wins
        do_open("b");
        vote(1, 4, "b1");
        vote(3, 5, "b2");
        do_close("b");
        check("b_tie_flag", 32'(tie), 1);
        do_clear("b");

        // Repeat voter: nacked only with lockout, forgotten after clear
        do_open("l");
        vote(4, 7, "l1");
        vote(4, 7, "l2");
        do_clear("l");
        do_open("l");
        vote(4, 7, "l3");
        do_close("l");
        do_clear("l");

        // Vote offered in IDLE is not accepted
        vif.vote_valid = 1'b1;
        vif.vote_cand  = 3'd0;
        vif.vote_vid   = 4'd0;
        check("idle_ready", 32'(vif.vote_ready), 0);
        step();
        vif.vote_valid = 1'b0;
        check("idle_ack",   32'(vif.vote_ack),  0);
        check("idle_nack",  32'(vif.vote_nack), 0);
        check("idle_total", 32'(total),         0);

        // Vote in the same cycle as close is still counted
        do_open("c");
        vote(6, 8, "c0");
        begin
            bit exp_ack;
            vif.vote_valid = 1'b1;
            vif.vote_cand  = 3'd6;
            vif.vote_vid   = 4'd9;
            cmd_close      = 1'b1;
            exp_ack = model_vote(6, 9);
            step();
            vif.vote_valid = 1'b0;
            cmd_close      = 1'b0;
            check("c_close_ack", 32'(vif.vote_ack), 32'(exp_ack));
            run_scan("c");
        end
        do_clear("c");

        // Reset in the middle of the scan aborts it
        do_open("r");
        vote(0, 1, "r1");
        cmd_close = 1'b1;
        step();
        cmd_close = 1'b0;
        repeat (3) step();
        check("r_mid_tally", 32'(state), 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_clear();
        check("r_state", 32'(state), 0);
        check("r_total", 32'(total), 0);
        repeat (NC) step();
        check("r_no_result", 32'(state), 0);

        // Clear wins over simultaneous open / close
        cmd_clear = 1'b1;
        cmd_open  = 1'b1;
        step();
        cmd_clear = 1'b0;
        cmd_open  = 1'b0;
        check("clr_open_state", 32'(state), 0);
        do_open("co");
        cmd_clear = 1'b1;
        cmd_close = 1'b1;
        step();
        cmd_clear = 1'b0;
        cmd_close = 1'b0;
        check("clr_close_state", 32'(state), 0);
        model_clear();

        // Randomized polls
        for (int r = 0; r < 15; r++) begin
            int nv;
            int crange;
            nv     = int'($urandom_range(0, 14));
            crange = ($urandom_range(0, 1) == 0) ? 2 : NC - 1;
            do_open("rnd");
            for (int v = 0; v < nv; v++) begin
                if ($urandom_range(0, 3) == 0) step();
                vote(int'($urandom_range(0, crange)), int'($urandom_range(0, 2**VW - 1)), "rnd");
            end
            check_counts("rnd");
            do_close("rnd");
            do_clear("rnd");
        end

        // Narrow instance: 2-bit counters, 3-bit total, 3 candidates
        s_open = 1'b1;
        step();
        s_open = 1'b0;
        check("s_open_state", 32'(s_state), 1);
        s_vote(0, 0, 1'b1, "s_c0_1");
        s_vote(0, 1, 1'b1, "s_c0_2");
        s_vote(0, 2, 1'b1, "s_c0_3");
        s_vote(0, 3, 1'b0, "s_c0_sat");
        s_vote(3, 4, 1'b0, "s_range");
        s_vote(1, 5, 1'b1, "s_c1_1");
        s_vote(1, 6, 1'b1, "s_c1_2");
        s_vote(1, 7, 1'b1, "s_c1_3");
        s_vote(2, 8, 1'b1, "s_c2_1");
        s_vote(2, 9, 1'b0, "s_tot_sat");
        check("s_total", 32'(s_total), 7);
        s_rd_sel = 2'd0; #1;
        check("s_rd0", 32'(s_rd_count), 3);
        s_rd_sel = 2'd1; #1;
        check("s_rd1", 32'(s_rd_count), 3);
        s_rd_sel = 2'd2; #1;
        check("s_rd2", 32'(s_rd_count), 1);
        s_close = 1'b1;
        step();
        s_close = 1'b0;
        check("s_tally", 32'(s_state), 2);
        repeat (SNC - 1) step();
        check("s_tally_last", 32'(s_state), 2);
        step();
        check("s_result", 32'(s_state),        3);
        check("s_widx",   32'(s_winner_idx),   0);
        check("s_wvalid", 32'(s_winner_valid), 1);
        check("s_tie",    32'(s_tie),          1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
